i2c_byte_ctrl: RTL

- Byte-level sequencer sitting between a host command interface and i2c_phy.
- Expands each host byte command into optional START, 8 data bits MSB-first plus 1 ACK bit, and optional STOP.
- Issues these as single-cycle bit strobes to the PHY and collects returned read data and ACK status.
- Includes a watchdog that aborts the command if the PHY stalls.

---
 rtl/i2c_byte_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C sequencer: expands host byte commands into START / 8 data bits + ACK / STOP
// strobes for i2c_phy, collects read data and ACK status, and aborts on a stalled PHY.
module i2c_byte_ctrl #(
    parameter int unsigned WDOG_CYCLES = 65535,
    parameter int unsigned WDOG_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic       cmd_nack,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ack_err,
    output logic       cmd_err,
    output logic       done,
    output logic       busy,
    output logic       phy_start_bit,
    output logic       phy_stop_bit,
    output logic       phy_write_bit,
    output logic       phy_read_bit,
    output logic       phy_tx_data,
    input  logic       phy_busy,
    input  logic       phy_rx_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WR_BIT,
        S_WR_ACKRD,
        S_RD_BIT,
        S_RD_ACKWR,
        S_STOP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_STROBE,
        PH_SKIP,
        PH_WAIT
    } phase_t;

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

    state_t              r_state;
    state_t              w_next;
    phase_t              r_phase;
    logic                r_ready;
    logic                r_cmd_write;
    logic                r_cmd_read;
    logic                r_cmd_stop;
    logic                r_cmd_nack;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit_cnt;
    logic [WDOG_W-1:0]   r_wdog;
    logic [7:0]          r_data_out;
    logic                r_ack_err;
    logic                r_cmd_err;

    logic                w_accept;
    logic                w_illegal;
    logic                w_bitop;
    logic                w_strobe;
    logic                w_complete;
    logic                w_wdog_trip;
    logic                w_load_dout;

    assign w_accept    = cmd_valid && r_ready;
    assign w_illegal   = cmd_write && cmd_read;
    assign w_bitop     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_strobe    = w_bitop && (r_phase == PH_STROBE) && !phy_busy;
    assign w_complete  = w_bitop && (r_phase == PH_WAIT) && !phy_busy;
    assign w_wdog_trip = w_bitop && phy_busy && (r_wdog >= WDOG_LIMIT);
    // Read data is published on the edge entering DONE so it is valid during the done pulse.
    assign w_load_dout = w_bitop && !w_wdog_trip && (w_next == S_DONE) && r_cmd_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal)      w_next = S_DONE;
                    else if (cmd_start) w_next = S_START;
                    else if (cmd_write) w_next = S_WR_BIT;
                    else if (cmd_read)  w_next = S_RD_BIT;
                    else if (cmd_stop)  w_next = S_STOP;
                    else                w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: begin
                if (w_wdog_trip) begin
                    w_next = S_DONE;
                end else if (w_complete) begin
                    case (r_state)
                        S_START: begin
                            if (r_cmd_write)     w_next = S_WR_BIT;
                            else if (r_cmd_read) w_next = S_RD_BIT;
                            else if (r_cmd_stop) w_next = S_STOP;
                            else                 w_next = S_DONE;
                        end
                        S_WR_BIT: w_next = (r_bit_cnt == 3'd0) ? S_WR_ACKRD : S_WR_BIT;
                        S_RD_BIT: w_next = (r_bit_cnt == 3'd0) ? S_RD_ACKWR : S_RD_BIT;
                        S_WR_ACKRD, S_RD_ACKWR: w_next = r_cmd_stop ? S_STOP : S_DONE;
                        default: w_next = S_DONE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= PH_STROBE;
            r_ready     <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_stop  <= 1'b0;
            r_cmd_nack  <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_wdog      <= '0;
            r_data_out  <= '0;
            r_ack_err   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_ready <= (w_next == S_IDLE);

            if (!w_bitop || w_complete || w_wdog_trip) begin
                r_phase <= PH_STROBE;
            end else if (w_strobe) begin
                r_phase <= PH_SKIP;
            end else if (r_phase == PH_SKIP) begin
                r_phase <= PH_WAIT;
            end

            if (!w_bitop || w_strobe || w_complete) begin
                r_wdog <= '0;
            end else if (phy_busy && (r_wdog < WDOG_LIMIT)) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_accept) begin
                r_cmd_write <= cmd_write;
                r_cmd_read  <= cmd_read;
                r_cmd_stop  <= cmd_stop;
                r_cmd_nack  <= cmd_nack;
                r_shift     <= data_in;
                r_bit_cnt   <= 3'd7;
                r_ack_err   <= 1'b0;
                r_cmd_err   <= w_illegal;
            end else if (w_wdog_trip) begin
                r_cmd_err <= 1'b1;
            end else if (w_complete) begin
                case (r_state)
                    S_WR_BIT: begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                    S_RD_BIT: begin
                        r_shift   <= {r_shift[6:0], phy_rx_data};
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                    S_WR_ACKRD: r_ack_err <= phy_rx_data;
                    default: ;
                endcase
            end

            if (w_load_dout) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign cmd_ready     = r_ready;
    assign data_out      = r_data_out;
    assign ack_err       = r_ack_err;
    assign cmd_err       = r_cmd_err;
    assign done          = (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);
    assign phy_start_bit = w_strobe && (r_state == S_START);
    assign phy_stop_bit  = w_strobe && (r_state == S_STOP);
    assign phy_write_bit = w_strobe && ((r_state == S_WR_BIT) || (r_state == S_RD_ACKWR));
    assign phy_read_bit  = w_strobe && ((r_state == S_RD_BIT) || (r_state == S_WR_ACKRD));
    assign phy_tx_data   = (r_state == S_WR_BIT)   ? r_shift[7] :
                           (r_state == S_RD_ACKWR) ? r_cmd_nack : 1'b0;

endmodule
